// File: rtl/arr_mult_pkg.sv
// Shared constants and rank-placement helpers for the pipelined array multiplier.
package arr_mult_pkg;

  localparam int DEF_INPUT_BIT_SIZE = 32;
  localparam int DEF_STAGES         = 4;

  // Number of adder rows completed ahead of register rank k: ceil(k*rows/stages).
  function automatic int rank_row(input int k, input int rows, input int stages);
    return (k * rows + stages - 1) / stages;
  endfunction

  // True when an intermediate rank (k = 1..stages-1) sits in front of row p.
  function automatic bit is_rank_pos(input int p, input int rows, input int stages);
    for (int k = 1; k < stages; k++) begin
      if (rank_row(k, rows, stages) == p) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/arr_mult_row.sv
// One combinational ripple adder row of the array: WIDTH full adders with carry in/out.
module arr_mult_row #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic w_carry;

  always_comb begin
    w_carry = i_cin;
    o_sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_sum[i] = i_x[i] ^ i_y[i] ^ w_carry;
      w_carry  = (i_x[i] & i_y[i]) | (w_carry & (i_x[i] ^ i_y[i]));
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/arr_multiplier_pipe.sv
// Pipelined array multiplier, unsigned or Baugh-Wooley signed per operand pair,
// with a single global advance enable doubling as the input ready.
module arr_multiplier_pipe
  import arr_mult_pkg::*;
#(
  parameter int INPUT_BIT_SIZE = DEF_INPUT_BIT_SIZE,
  parameter int STAGES         = DEF_STAGES
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          InValid,
  output logic                          InReady,
  input  logic [INPUT_BIT_SIZE-1:0]     InA,
  input  logic [INPUT_BIT_SIZE-1:0]     InB,
  input  logic                          Signed,
  output logic                          OutValid,
  input  logic                          OutReady,
  output logic [2*INPUT_BIT_SIZE-1:0]   Out
);

  localparam int N               = INPUT_BIT_SIZE;
  localparam int OUTPUT_BIT_SIZE = 2 * N;
  localparam int ROW_SIZE        = N - 1;

  if (N < 2 || N > 64) begin : g_bad_width
    $error("arr_multiplier_pipe: INPUT_BIT_SIZE must be within 2..64");
  end
  if (STAGES < 1 || STAGES > ROW_SIZE) begin : g_bad_stages
    $error("arr_multiplier_pipe: STAGES must be within 1..INPUT_BIT_SIZE-1");
  end

  logic w_en;
  assign w_en    = !OutValid || OutReady;
  assign InReady = w_en;

  // Each row r holds the running high word (w_hi), the settled low product bits
  // (w_lo) and only the multiplier bits still to be consumed (w_b).
  for (genvar r = 0; r < ROW_SIZE; r++) begin : g_row
    localparam logic [N-1:0] INV = (r + 1 == N - 1) ? {1'b0, {(N-1){1'b1}}}
                                                    : {1'b1, {(N-1){1'b0}}};
    logic [N-1:0]   w_a;
    logic [N-1:r+1] w_b;
    logic [N-1:0]   w_hi;
    logic [r:0]     w_lo;
    logic           w_sg;
    logic           w_vl;
    logic [N-1:0]   w_pp;
    logic [N-1:0]   w_sum;
    logic           w_cout;
    logic [N-1:0]   w_hi_out;
    logic [r+1:0]   w_lo_out;

    if (r == 0) begin : g_src
      logic [N-1:0] w_pp0;
      assign w_pp0 = (InA & {N{InB[0]}}) ^ ({1'b1, {(N-1){1'b0}}} & {N{Signed}});
      assign w_a   = InA;
      assign w_b   = InB[N-1:1];
      // Spare MSB of the first high word carries the signed-mode +1 at bit N.
      assign w_hi  = {Signed, w_pp0[N-1:1]};
      assign w_lo  = w_pp0[0];
      assign w_sg  = Signed;
      assign w_vl  = InValid;
    end else if (is_rank_pos(r, ROW_SIZE, STAGES)) begin : g_rank
      logic [N-1:0]   r_a;
      logic [N-1:r+1] r_b;
      logic [N-1:0]   r_hi;
      logic [r:0]     r_lo;
      logic           r_sg;
      logic           r_vl;

      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          r_a  <= '0;
          r_b  <= '0;
          r_hi <= '0;
          r_lo <= '0;
          r_sg <= 1'b0;
          r_vl <= 1'b0;
        end else if (w_en) begin
          r_a  <= g_row[r-1].w_a;
          r_b  <= g_row[r-1].w_b[N-1:r+1];
          r_hi <= g_row[r-1].w_hi_out;
          r_lo <= g_row[r-1].w_lo_out;
          r_sg <= g_row[r-1].w_sg;
          r_vl <= g_row[r-1].w_vl;
        end
      end

      assign w_a  = r_a;
      assign w_b  = r_b;
      assign w_hi = r_hi;
      assign w_lo = r_lo;
      assign w_sg = r_sg;
      assign w_vl = r_vl;
    end else begin : g_wire
      assign w_a  = g_row[r-1].w_a;
      assign w_b  = g_row[r-1].w_b[N-1:r+1];
      assign w_hi = g_row[r-1].w_hi_out;
      assign w_lo = g_row[r-1].w_lo_out;
      assign w_sg = g_row[r-1].w_sg;
      assign w_vl = g_row[r-1].w_vl;
    end

    assign w_pp = (w_a & {N{w_b[r+1]}}) ^ (INV & {N{w_sg}});

    arr_mult_row #(
      .WIDTH (N)
    ) u_row (
      .i_x    (w_hi),
      .i_y    (w_pp),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
    );

    assign w_hi_out = {w_cout, w_sum[N-1:1]};
    assign w_lo_out = {w_sum[0], w_lo};
  end

  logic [N-1:0]               w_fin_hi;
  logic [N-1:0]               w_fin_lo;
  logic                       w_fin_sg;
  logic                       w_fin_vl;
  logic [OUTPUT_BIT_SIZE-1:0] w_prod;
  logic [OUTPUT_BIT_SIZE-1:0] r_out;
  logic                       r_out_vl;

  assign w_fin_hi = g_row[ROW_SIZE-1].w_hi_out;
  assign w_fin_lo = g_row[ROW_SIZE-1].w_lo_out;
  assign w_fin_sg = g_row[ROW_SIZE-1].w_sg;
  assign w_fin_vl = g_row[ROW_SIZE-1].w_vl;
  // Signed-mode +1 at bit 2N-1 reduces to flipping the product MSB.
  assign w_prod   = {w_fin_hi[N-1] ^ w_fin_sg, w_fin_hi[N-2:0], w_fin_lo};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_out    <= '0;
      r_out_vl <= 1'b0;
    end else if (w_en) begin
      r_out    <= w_prod;
      r_out_vl <= w_fin_vl;
    end
  end

  assign Out      = r_out;
  assign OutValid = r_out_vl;

endmodule

// File: tb/tb_arr_multiplier_pipe.sv
// Directed and table-driven checks of arr_multiplier_pipe at 4/3, plus random
// streams through 32-bit instances with one and with thirty-one ranks.
module tb_arr_multiplier_pipe;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [7:0] e;
  } vec_t;

  logic        Clk;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [3:0]  InA;
  logic [3:0]  InB;
  logic        Signed;
  logic        OutValid;
  logic        OutReady;
  logic [7:0]  Out;

  logic        in_valid32;
  logic [31:0] in_a32;
  logic [31:0] in_b32;
  logic        signed32;
  logic        out_ready32;
  logic        ir_s1, ov_s1, ir_s31, ov_s31;
  logic [63:0] out_s1, out_s31;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]  exp_q [$];
  logic [63:0] q_s1  [$];
  logic [63:0] q_s31 [$];

  logic stream_mon = 1'b0;
  int   n_stream   = 0;
  int   first_cyc  = 0;
  int   last_cyc   = 0;

  arr_multiplier_pipe #(.INPUT_BIT_SIZE(4), .STAGES(3)) u_dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InA(InA), .InB(InB), .Signed(Signed),
    .OutValid(OutValid), .OutReady(OutReady), .Out(Out)
  );

  arr_multiplier_pipe #(.INPUT_BIT_SIZE(32), .STAGES(1)) u_dut_s1 (
    .Clk(Clk), .Reset(Reset), .InValid(in_valid32), .InReady(ir_s1),
    .InA(in_a32), .InB(in_b32), .Signed(signed32),
    .OutValid(ov_s1), .OutReady(out_ready32), .Out(out_s1)
  );

  arr_multiplier_pipe #(.INPUT_BIT_SIZE(32), .STAGES(31)) u_dut_s31 (
    .Clk(Clk), .Reset(Reset), .InValid(in_valid32), .InReady(ir_s31),
    .InA(in_a32), .InB(in_b32), .Signed(signed32),
    .OutValid(ov_s31), .OutReady(out_ready32), .Out(out_s31)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int ia, ib, p;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    p  = ia * ib;
    return 8'(p);
  endfunction

  function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint ia, ib, p;
    ia = s ? longint'($signed(a)) : longint'(a);
    ib = s ? longint'($signed(b)) : longint'(b);
    p  = ia * ib;
    return 64'(p);
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [7:0] e);
    int n = 0;
    @(negedge Clk);
    InValid = 1'b1; InA = a; InB = b; Signed = s;
    #1;
    while (!InReady && n < 50) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (!InReady) note_fail("accept_timeout", 64'(n));
    else exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge Clk);
    InValid = 1'b0;
  endtask

  task automatic drain_main(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge Clk);
    @(negedge Clk);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge Clk) begin
    #1;
    if (Reset && OutValid && OutReady) begin
      if (stream_mon) begin
        if (n_stream == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_stream++;
      end
      if (exp_q.size() == 0) note_fail("main_unexpected_out", 64'(Out));
      else chk("main_product", 64'(Out), 64'(exp_q.pop_front()));
    end
  end

  always @(negedge Clk) begin
    #1;
    if (Reset && ov_s1 && out_ready32) begin
      if (q_s1.size() == 0) note_fail("s1_unexpected_out", out_s1);
      else chk("s1_product", out_s1, q_s1.pop_front());
    end
    if (Reset && ov_s31 && out_ready32) begin
      if (q_s31.size() == 0) note_fail("s31_unexpected_out", out_s31);
      else chk("s31_product", out_s31, q_s31.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [14];
    logic [3:0]  ra, rb;
    logic        rs;
    logic [31:0] a32, b32;
    logic        s32;
    logic [7:0]  hold_val;

    vecs[0]  = '{4'd15, 4'd15, 1'b0, 8'hE1};
    vecs[1]  = '{4'd8,  4'd8,  1'b1, 8'h40};
    vecs[2]  = '{4'd8,  4'd7,  1'b0, 8'h38};
    vecs[3]  = '{4'd8,  4'd7,  1'b1, 8'hC8};
    vecs[4]  = '{4'd12, 4'd5,  1'b0, 8'h3C};
    vecs[5]  = '{4'd12, 4'd5,  1'b1, 8'hEC};
    vecs[6]  = '{4'd9,  4'd14, 1'b0, 8'h7E};
    vecs[7]  = '{4'd9,  4'd14, 1'b1, 8'h0E};
    vecs[8]  = '{4'd1,  4'd8,  1'b0, 8'h08};
    vecs[9]  = '{4'd15, 4'd15, 1'b1, 8'h01};
    vecs[10] = '{4'd0,  4'd13, 1'b0, 8'h00};
    vecs[11] = '{4'd15, 4'd1,  1'b1, 8'hFF};
    vecs[12] = '{4'd15, 4'd1,  1'b0, 8'h0F};
    vecs[13] = '{4'd7,  4'd7,  1'b1, 8'h31};

    Reset = 1'b0; InValid = 1'b0; InA = '0; InB = '0; Signed = 1'b0; OutReady = 1'b1;
    in_valid32 = 1'b0; in_a32 = '0; in_b32 = '0; signed32 = 1'b0; out_ready32 = 1'b1;

    #12;
    chk("rst_outvalid", 64'(OutValid), 64'd0);
    chk("rst_out",      64'(Out),      64'd0);
    chk("rst_inready",  64'(InReady),  64'd1);
    chk("rst_s31_out",  out_s31,       64'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // 15*15 unsigned: valid on the third edge counting the accepting one
    drive(4'd15, 4'd15, 1'b0, 8'hE1);
    @(negedge Clk); InValid = 1'b0; #2;
    chk("lat_after_edge1_valid", 64'(OutValid), 64'd0);
    @(negedge Clk); #2;
    chk("lat_after_edge2_valid", 64'(OutValid), 64'd0);
    @(negedge Clk); #2;
    chk("lat_after_edge3_valid", 64'(OutValid), 64'd1);
    chk("lat_after_edge3_out",   64'(Out),      64'hE1);
    drain_main("lat_drain");

    foreach (vecs[i]) drive(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e);
    idle();
    drain_main("table_drain");

    stream_mon = 1'b1;
    n_stream   = 0;
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      drive(ra, rb, rs, model4(ra, rb, rs));
    end
    idle();
    drain_main("stream_drain");
    stream_mon = 1'b0;
    chk("stream_count", 64'(n_stream), 64'd16);
    chk("stream_span",  64'(last_cyc - first_cyc), 64'd15);

    // Backpressure with the pipeline full
    @(negedge Clk); OutReady = 1'b0;
    drive(4'd3,  4'd5, 1'b0, 8'h0F);
    drive(4'd10, 4'd3, 1'b1, 8'hEE);
    drive(4'd6,  4'd6, 1'b0, 8'h24);
    hold_val = 8'h0F;
    idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_inready",  64'(InReady),  64'd0);
      chk("stall_outvalid", 64'(OutValid), 64'd1);
      chk("stall_out_hold", 64'(Out),      64'(hold_val));
      @(negedge Clk);
    end
    OutReady = 1'b1;
    drain_main("stall_drain");

    // Reset with three products in flight
    @(negedge Clk); OutReady = 1'b0;
    drive(4'd13, 4'd11, 1'b0, 8'h8F);
    drive(4'd5,  4'd11, 1'b1, 8'hE7);
    drive(4'd2,  4'd3,  1'b0, 8'h06);
    @(negedge Clk); InValid = 1'b0; #2;
    chk("pre_reset_full", 64'(OutValid), 64'd1);
    Reset = 1'b0;
    #1;
    chk("async_rst_outvalid", 64'(OutValid), 64'd0);
    chk("async_rst_out",      64'(Out),      64'd0);
    chk("async_rst_inready",  64'(InReady),  64'd1);
    exp_q.delete();
    @(negedge Clk);
    chk("held_rst_outvalid", 64'(OutValid), 64'd0);
    Reset = 1'b1; OutReady = 1'b1;
    InValid = 1'b1; InA = 4'd4; InB = 4'd4; Signed = 1'b0;
    #1;
    chk("release_inready", 64'(InReady), 64'd1);
    exp_q.push_back(8'h10);
    @(negedge Clk); InValid = 1'b0; #2;
    chk("post_rst_no_stale1", 64'(OutValid), 64'd0);
    @(negedge Clk); #2;
    chk("post_rst_no_stale2", 64'(OutValid), 64'd0);
    drain_main("post_rst_drain");

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          drive(4'(a), 4'(b), 1'(s), model4(4'(a), 4'(b), 1'(s)));
    idle();
    drain_main("exhaustive_drain");

    for (int i = 0; i < 40; i++) begin
      case (i)
        0:       begin a32 = 32'h8000_0000; b32 = 32'h8000_0000; s32 = 1'b1; end
        1:       begin a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; s32 = 1'b0; end
        2:       begin a32 = 32'h8000_0000; b32 = 32'h7FFF_FFFF; s32 = 1'b1; end
        3:       begin a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; s32 = 1'b1; end
        default: begin a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1)); end
      endcase
      @(negedge Clk);
      in_valid32 = 1'b1; in_a32 = a32; in_b32 = b32; signed32 = s32;
      #1;
      if (ir_s1)  q_s1.push_back(model32(a32, b32, s32));  else note_fail("s1_not_ready", 64'd0);
      if (ir_s31) q_s31.push_back(model32(a32, b32, s32)); else note_fail("s31_not_ready", 64'd0);
    end
    @(negedge Clk); in_valid32 = 1'b0;
    for (int i = 0; i < 100 && (q_s1.size() != 0 || q_s31.size() != 0); i++) @(negedge Clk);
    @(negedge Clk);
    chk("s1_drain",  64'(q_s1.size()),  64'd0);
    chk("s31_drain", 64'(q_s31.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arr_multiplier_pipe.md
ARR_MULTIPLIER_PIPE -- requirements
Module: arr_multiplier_pipe

Interface
REQ-001 Parameter INPUT_BIT_SIZE, default 32, operand width in bits (legal range 2..64).
REQ-002 Parameter STAGES, default 4, number of pipeline register ranks (legal range 1..INPUT_BIT_SIZE-1).
REQ-003 Derived OUTPUT_BIT_SIZE = 2*INPUT_BIT_SIZE and ROW_SIZE = INPUT_BIT_SIZE-1; neither is user-overridable.
REQ-004 Clk  input  1  single clock; all state on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 InValid  input  1  operand pair on InA/InB/Signed is valid.
REQ-007 InReady  output  1  block accepts operands this cycle.
REQ-008 InA  input  INPUT_BIT_SIZE  multiplicand.
REQ-009 InB  input  INPUT_BIT_SIZE  multiplier.
REQ-010 Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
REQ-011 OutValid  output  1  Out holds a valid product.
REQ-012 OutReady  input  1  downstream accepts product this cycle.
REQ-013 Out  output  OUTPUT_BIT_SIZE  full-width product.

Function
REQ-014 Transfer on input side occurs when InValid and InReady are both 1 at a rising Clk edge; on output side when OutValid and OutReady are both 1.
REQ-015 Pipeline advance enable = !OutValid | OutReady; InReady SHALL equal this enable, combinationally.
REQ-016 When enable is 0, every pipeline rank, its valid bit and its Signed bit SHALL hold; no data lost or duplicated.
REQ-017 Latency: product of an accepted pair SHALL appear on Out with OutValid=1 exactly STAGES cycles after acceptance, absent stalls.
REQ-018 Throughput: one product per cycle when OutReady is held 1; bubbles (InValid=0) propagate as valid=0 ranks.
REQ-019 Array: ROW_SIZE carry-save/ripple adder rows, row r adding partial product InA&InB[r+1] to prior row's shifted sum; register ranks placed after rows ceil(k*ROW_SIZE/STAGES), k=1..STAGES-1, plus final output rank.
REQ-020 Operand bits and Signed not yet consumed by later rows SHALL travel with each rank.
REQ-021 Signed=0: Out = InA*InB, unsigned, exact over OUTPUT_BIT_SIZE bits.
REQ-022 Signed=1: Out = InA*InB as two's complement via Baugh-Wooley (invert MSB cross terms, add 1 at bits INPUT_BIT_SIZE and OUTPUT_BIT_SIZE-1); exact, including most-negative x most-negative.
REQ-023 Mixed-mode pairs in flight SHALL each use their own sampled Signed bit.
REQ-024 Out SHALL hold its value while OutValid=1 and OutReady=0.
REQ-025 Out value when OutValid=0 is don't-care for checkers but SHALL not be X after reset.

Reset
REQ-026 Reset=0 SHALL asynchronously clear all valid bits, all data ranks, Out to 0 and OutValid to 0.
REQ-027 Assertion mid-operation discards all in-flight products; none SHALL emerge after release.
REQ-028 InReady SHALL be 1 during and immediately after reset (OutValid=0).
REQ-029 Deassertion takes effect synchronously at the next rising Clk; first acceptance possible that edge.

Structure
REQ-030 Package arr_mult_pkg holds default width/stage constants and a function computing the row index of each register rank.
REQ-031 One sub-module arr_mult_row: one combinational adder row (INPUT_BIT_SIZE full adders, generic Cin/carry-out), instantiated ROW_SIZE times via generate.
REQ-032 Parameter legality checked at elaboration; illegal STAGES is an elaboration error.

Verification (INPUT_BIT_SIZE=4, STAGES=3 unless stated)
REQ-033 Unsigned InA=15, InB=15, Signed=0 -> Out=225 (0xE1), OutValid exactly 3 cycles after accept.
REQ-034 Signed InA=-8, InB=-8 -> Out=64 (0x40); InA=-8, InB=7 -> Out=-56 (0xC8); back-to-back with alternating Signed, results in order.
REQ-035 Stream 16 random pairs, OutReady=1 -> 16 correct products on 16 consecutive cycles after 3-cycle fill.
REQ-036 OutReady=0 for 5 cycles with pipeline full -> InReady=0, Out stable, no loss; release -> remaining products in order.
REQ-037 Reset=0 with 3 products in flight -> OutValid=0 immediately, Out=0; after release no stale product appears.
REQ-038 Exhaustive all 256 pairs x both modes at INPUT_BIT_SIZE=4, plus random at 32/STAGES=1 and 32/STAGES=31, against reference model.
